// File: rtl/interconn_arb_pkg.sv
// Shared defaults and FIFO-entry layout helpers for the MVU crossbar.
// An entry is packed as {mask, addr, word}, with the word in the LSBs.
package interconn_arb_pkg;
  localparam int N_DEF     = 8;
  localparam int W_DEF     = 64;
  localparam int BADDR_DEF = 15;
  localparam int DEPTH_DEF = 4;

  function automatic int entry_w(input int n, input int baddr, input int w);
    return n + baddr + w;
  endfunction

  function automatic int addr_lsb(input int w);
    return w;
  endfunction

  function automatic int mask_lsb(input int baddr, input int w);
    return w + baddr;
  endfunction
endpackage

// File: rtl/interconn_rr_arb.sv
// N-wide round-robin arbiter. It grants the first requester at or above the
// pointer, and the pointer moves to one past the winner on each grant.
module interconn_rr_arb #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] grant
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0]  ptr, nxt;
  logic [2*N-1:0] req2, gr2;
  logic [N-1:0]   rot, grot;
  logic           found;

  // Rotate requests so the pointer sits at bit 0, pick the lowest bit, then rotate back.
  always_comb begin
    req2  = {req, req} >> ptr;
    rot   = req2[N-1:0];
    grot  = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        grot[k] = 1'b1;
        found   = 1'b1;
      end
    end
    gr2   = {grot, grot} << ptr;
    grant = en ? gr2[2*N-1:N] : '0;
    nxt   = ptr;
    for (int i = 0; i < N; i++) begin
      if (gr2[N+i]) nxt = (i == N-1) ? '0 : PW'(i + 1);
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)            ptr <= '0;
    else if (en && found)  ptr <= nxt;
  end
endmodule

// File: rtl/interconn_arb.sv
// N-port MVU-to-MVU crossbar. Each source has a FIFO whose head carries a pending
// destination mask. Each destination round-robins over the pending heads and registers the result.
module interconn_arb
  import interconn_arb_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int W     = W_DEF,
  parameter int BADDR = BADDR_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic [N*N-1:0]     send_to,
  input  logic [N-1:0]       send_en,
  input  logic [N*BADDR-1:0] send_addr,
  input  logic [N*W-1:0]     send_word,
  output logic [N-1:0]       send_rdy,
  output logic [N*N-1:0]     recv_from,
  output logic [N-1:0]       recv_en,
  output logic [N*BADDR-1:0] recv_addr,
  output logic [N*W-1:0]     recv_word,
  input  logic [N-1:0]       recv_rdy
);
  localparam int EW       = entry_w(N, BADDR, W);
  localparam int ADDR_LSB = addr_lsb(W);
  localparam int MASK_LSB = mask_lsb(BADDR, W);
  localparam int AW       = $clog2(DEPTH);
  localparam int CW       = $clog2(DEPTH + 1);

  logic [N-1:0][N-1:0]     pend;   // [src][dest]
  logic [N-1:0][N-1:0]     req_t;  // [dest][src]
  logic [N-1:0][N-1:0]     gnt;    // [dest][src]
  logic [N-1:0][BADDR-1:0] head_addr;
  logic [N-1:0][W-1:0]     head_word;

  always_comb begin
    req_t = '0;
    for (int j = 0; j < N; j++)
      for (int i = 0; i < N; i++)
        req_t[j][i] = pend[i][j];
  end

  for (genvar i = 0; i < N; i++) begin : g_src
    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] head, entry_in;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          live, push, pop;
    logic [N-1:0]  pend_r, taken, left;

    assign entry_in    = {send_to[i*N +: N], send_addr[i*BADDR +: BADDR], send_word[i*W +: W]};
    assign head        = mem[rd_ptr];
    assign send_rdy[i] = (count != CW'(DEPTH));
    // An empty mask has no destination, so it never takes a slot.
    assign push        = send_en[i] & send_rdy[i] & (|send_to[i*N +: N]);

    always_comb begin
      taken = '0;
      for (int j = 0; j < N; j++) taken[j] = gnt[j][i];
    end

    assign left = pend_r & ~taken;
    assign pop  = live & ~(|left);

    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= entry_in;
    end

    // The head stays in the FIFO until its last destination is served, then the next
    // head loads one edge later. This keeps at most one entry per source in flight.
    always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        live   <= 1'b0;
        pend_r <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
        if (live) begin
          pend_r <= left;
          if (pop) live <= 1'b0;
        end else if (count != '0) begin
          live   <= 1'b1;
          pend_r <= head[MASK_LSB +: N];
        end
      end
    end

    assign pend[i]      = pend_r;
    assign head_addr[i] = head[ADDR_LSB +: BADDR];
    assign head_word[i] = head[W-1:0];
  end

  for (genvar j = 0; j < N; j++) begin : g_dst
    logic             en_r;
    logic [N-1:0]     from_r;
    logic [BADDR-1:0] addr_r, addr_mux;
    logic [W-1:0]     word_r, word_mux;

    interconn_rr_arb #(.N(N)) u_arb (
      .clk   (clk),
      .clr_n (clr_n),
      .req   (req_t[j]),
      .en    (recv_rdy[j]),
      .grant (gnt[j])
    );

    always_comb begin
      addr_mux = '0;
      word_mux = '0;
      for (int i = 0; i < N; i++) begin
        if (gnt[j][i]) begin
          addr_mux = addr_mux | head_addr[i];
          word_mux = word_mux | head_word[i];
        end
      end
    end

    always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
        en_r   <= 1'b0;
        from_r <= '0;
        addr_r <= '0;
        word_r <= '0;
      end else begin
        en_r <= |gnt[j];
        if (|gnt[j]) begin
          from_r <= gnt[j];
          addr_r <= addr_mux;
          word_r <= word_mux;
        end
      end
    end

    assign recv_en[j]                 = en_r;
    assign recv_from[j*N +: N]        = from_r;
    assign recv_addr[j*BADDR +: BADDR] = addr_r;
    assign recv_word[j*W +: W]        = word_r;
  end
endmodule

// File: tb/tb_interconn_arb.sv
// Directed bench for interconn_arb: table of single sends plus hand-written
// sequences for contention, multicast backpressure, full FIFO and mid-traffic reset.
module tb_interconn_arb;
  logic         clk = 1'b0;
  logic         clr_n;
  logic [63:0]  send_to;
  logic [7:0]   send_en;
  logic [119:0] send_addr;
  logic [511:0] send_word;
  logic [7:0]   send_rdy;
  logic [63:0]  recv_from;
  logic [7:0]   recv_en;
  logic [119:0] recv_addr;
  logic [511:0] recv_word;
  logic [7:0]   recv_rdy;

  int total = 0;
  int bad   = 0;

  interconn_arb #(.N(8), .W(64), .BADDR(15), .DEPTH(4)) dut (
    .clk(clk), .clr_n(clr_n), .send_to(send_to), .send_en(send_en),
    .send_addr(send_addr), .send_word(send_word), .send_rdy(send_rdy),
    .recv_from(recv_from), .recv_en(recv_en), .recv_addr(recv_addr),
    .recv_word(recv_word), .recv_rdy(recv_rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          src;
    logic [7:0]  to;
    logic [14:0] addr;
    logic [63:0] word;
    logic [7:0]  exp_en;
    logic [7:0]  exp_from;
  } vec_t;

  vec_t tbl[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic offer(input int s, input logic [7:0] m, input logic [14:0] a, input logic [63:0] w);
    send_en[s]           = 1'b1;
    send_to[s*8 +: 8]    = m;
    send_addr[s*15 +: 15] = a;
    send_word[s*64 +: 64] = w;
  endtask

  task automatic do_reset();
    clr_n     = 1'b0;
    send_en   = '0;
    send_to   = '0;
    send_addr = '0;
    send_word = '0;
    recv_rdy  = 8'hFF;
    step();
    step();
    clr_n = 1'b1;
    step();
  endtask

  initial begin
    int k;
    logic [7:0] seen;
    logic [7:0] exp_order[4];

    tbl[0] = '{2, 8'h10, 15'h0123, 64'hDEAD,                 8'h10, 8'h04};
    tbl[1] = '{0, 8'h01, 15'h0001, 64'h1111,                 8'h01, 8'h01};
    tbl[2] = '{7, 8'h80, 15'h7FFF, 64'hFFFF_FFFF_FFFF_FFFF,  8'h80, 8'h80};
    tbl[3] = '{5, 8'hFF, 15'h2AAA, 64'h5555_0000_AAAA_1234,  8'hFF, 8'h20};
    tbl[4] = '{3, 8'h00, 15'h0777, 64'h0BAD,                 8'h00, 8'h00};
    tbl[5] = '{6, 8'h24, 15'h0042, 64'hCAFE_F00D,            8'h24, 8'h40};

    do_reset();
    chk("reset recv_en", recv_en, 8'h00);
    chk("reset send_rdy", send_rdy, 8'hFF);
    chk("reset recv_from", recv_from, 64'h0);
    chk("reset recv_word0", recv_word[63:0], 64'h0);

    // Single sends from an idle crossbar: strobe two cycles after the push edge.
    for (int v = 0; v < 6; v++) begin
      offer(tbl[v].src, tbl[v].to, tbl[v].addr, tbl[v].word);
      step();
      send_en = '0;
      chk("vec send_rdy", send_rdy, 8'hFF);
      step();
      chk("vec early", recv_en, 8'h00);
      step();
      chk("vec recv_en", recv_en, tbl[v].exp_en);
      for (int d = 0; d < 8; d++) begin
        if (tbl[v].exp_en[d]) begin
          chk("vec from", recv_from[d*8 +: 8], tbl[v].exp_from);
          chk("vec addr", recv_addr[d*15 +: 15], tbl[v].addr);
          chk("vec word", recv_word[d*64 +: 64], tbl[v].word);
        end
      end
      step();
      chk("vec strobe len", recv_en, 8'h00);
    end

    // Contention on dest5 from sources 0,1,3, then a burst incl. src5 with pointer at 4.
    do_reset();
    offer(0, 8'h20, 15'h10, 64'hA0);
    offer(1, 8'h20, 15'h11, 64'hA1);
    offer(3, 8'h20, 15'h13, 64'hA3);
    step();
    send_en = '0;
    step();
    exp_order = '{8'h01, 8'h02, 8'h08, 8'h00};
    for (int c = 0; c < 3; c++) begin
      step();
      chk("cont en", recv_en, 8'h20);
      chk("cont from", recv_from[40 +: 8], exp_order[c]);
    end
    step();
    chk("cont idle", recv_en, 8'h00);
    offer(0, 8'h20, 15'h20, 64'hB0);
    offer(1, 8'h20, 15'h21, 64'hB1);
    offer(3, 8'h20, 15'h23, 64'hB3);
    offer(5, 8'h20, 15'h25, 64'hB5);
    step();
    send_en = '0;
    step();
    exp_order = '{8'h20, 8'h01, 8'h02, 8'h08};
    for (int c = 0; c < 4; c++) begin
      step();
      chk("rr en", recv_en, 8'h20);
      chk("rr from", recv_from[40 +: 8], exp_order[c]);
    end

    // Multicast with dest2 stalled; second entry must wait for dest2.
    do_reset();
    recv_rdy = 8'hFB;
    offer(1, 8'h0F, 15'h0101, 64'hA1);
    step();
    offer(1, 8'h0F, 15'h0102, 64'hA2);
    step();
    send_en = '0;
    step();
    chk("mc first", recv_en, 8'h0B);
    chk("mc word0", recv_word[63:0], 64'hA1);
    chk("mc from3", recv_from[24 +: 8], 8'h02);
    step();
    chk("mc hold1", recv_en, 8'h00);
    step();
    chk("mc hold2", recv_en, 8'h00);
    recv_rdy = 8'hFF;
    step();
    chk("mc dest2", recv_en, 8'h04);
    chk("mc word2", recv_word[128 +: 64], 64'hA1);
    step();
    chk("mc gap", recv_en, 8'h00);
    step();
    chk("mc second", recv_en, 8'h0F);
    chk("mc word2b", recv_word[128 +: 64], 64'hA2);

    // Zero-mask push takes no slot; DEPTH pushes fill src0; extra offer ignored.
    do_reset();
    recv_rdy = 8'h00;
    offer(0, 8'h00, 15'h0, 64'hEEEE);
    step();
    for (int p = 0; p < 4; p++) begin
      offer(0, 8'h02, 15'(p), 64'h100 + 64'(p));
      step();
      if (p == 2) chk("fifo not full", send_rdy[0], 1'b1);
    end
    chk("fifo full", send_rdy[0], 1'b0);
    offer(0, 8'h02, 15'h7F, 64'hBAD);
    step();
    step();
    send_en = '0;
    chk("fifo still full", send_rdy[0], 1'b0);
    chk("fifo no out", recv_en, 8'h00);
    recv_rdy = 8'hFF;
    k = 0;
    seen = '0;
    for (int c = 0; c < 30; c++) begin
      step();
      seen = seen | recv_en;
      if (recv_en[1]) begin
        if (k < 4) chk("fifo order", recv_word[64 +: 64], 64'h100 + 64'(k));
        k++;
      end
    end
    chk("fifo count", k, 4);
    chk("fifo dests", seen, 8'h02);
    chk("fifo drained", send_rdy, 8'hFF);

    // Reset while src4 has entries queued and a strobe is live.
    do_reset();
    for (int p = 0; p < 3; p++) begin
      offer(4, 8'h40, 15'h0400 + 15'(p), 64'hC0 + 64'(p));
      step();
    end
    send_en = '0;
    chk("rst pre strobe", recv_en, 8'h40);
    #2;
    clr_n = 1'b0;
    #1;
    chk("rst recv_en", recv_en, 8'h00);
    chk("rst send_rdy", send_rdy, 8'hFF);
    step();
    clr_n = 1'b1;
    seen = '0;
    for (int c = 0; c < 8; c++) begin
      step();
      seen = seen | recv_en;
    end
    chk("rst no stale", seen, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
